// File: rtl/regheap_pkg.sv
// Shared constants, FSM state type and lane helper for the 64x16b register-heap drain.
// Optional build macro used by consumers: REGHEAP_DRAIN_RELU_EN.
package regheap_pkg;

    localparam int LANES      = 64;
    localparam int LANE_W     = 16;
    localparam int HEAP_W     = LANES * LANE_W;
    localparam int BEAT_LANES = 4;
    localparam int BEAT_W     = BEAT_LANES * LANE_W;
    localparam int NBEATS     = LANES / BEAT_LANES;
    localparam int IDX_W      = $clog2(NBEATS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_V = 2'd1,
        CLR    = 2'd2,
        STREAM = 2'd3
    } drain_state_t;

    // Negative lanes (sign bit set) collapse to zero; positive lanes pass through.
    function automatic logic [LANE_W-1:0] relu_lane(input logic [LANE_W-1:0] v);
        return v[LANE_W-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/regheap_drain_64x16b_if.sv
// Heap-side and output-side signals of the register-heap drain.
// Handshake: a beat transfers on a clk edge where out_valid && out_ready; while
// out_valid is high and out_ready low, out_data/out_idx/out_last are held stable.
interface regheap_drain_64x16b_if;
    import regheap_pkg::*;

    logic                snap_req;
    logic                heap_data_v;
    logic [HEAP_W-1:0]   heap_data;
    logic                heap_halt;
    logic                heap_clr;
    logic                out_valid;
    logic                out_ready;
    logic [BEAT_W-1:0]   out_data;
    logic [IDX_W-1:0]    out_idx;
    logic                out_last;
    logic                busy;
    logic                snap_drop;

    modport master (
        input  snap_req, heap_data_v, heap_data, out_ready,
        output heap_halt, heap_clr, out_valid, out_data, out_idx, out_last,
               busy, snap_drop
    );

    modport slave (
        output snap_req, heap_data_v, heap_data, out_ready,
        input  heap_halt, heap_clr, out_valid, out_data, out_idx, out_last,
               busy, snap_drop
    );

endinterface

// File: rtl/regheap_beat_mux.sv
// Combinational beat selector: picks beat idx out of the snapshot and, when
// REGHEAP_DRAIN_RELU_EN is defined, clamps negative lanes to zero.
module regheap_beat_mux
    import regheap_pkg::*;
(
    input  logic [HEAP_W-1:0] snap,
    input  logic [IDX_W-1:0]  idx,
    output logic [BEAT_W-1:0] beat
);

    logic [BEAT_W-1:0] raw;

    assign raw = snap[idx*BEAT_W +: BEAT_W];

`ifdef REGHEAP_DRAIN_RELU_EN
    always_comb begin
        beat = '0;
        for (int k = 0; k < BEAT_LANES; k++) begin
            beat[k*LANE_W +: LANE_W] = relu_lane(raw[k*LANE_W +: LANE_W]);
        end
    end
`else
    assign beat = raw;
`endif

endmodule

// File: rtl/regheap_drain_64x16b.sv
// Drains the 64x16b register heap: halt, capture 1024-bit snapshot, clear heap, then
// stream 16 beats of 64 bits. Optional lane ReLU via REGHEAP_DRAIN_RELU_EN.
module regheap_drain_64x16b
    import regheap_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    regheap_drain_64x16b_if.master        bus,
    output drain_state_t                  state_dbg
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

    drain_state_t       state, state_nxt;
    logic [HEAP_W-1:0]  snap_q;
    logic [IDX_W-1:0]   idx_q;
    logic               drop_q;
    logic               halt_c;
    logic               clr_c;
    logic               valid_c;
    logic               capture_c;
    logic               accept;
    logic               at_last;
    logic [BEAT_W-1:0]  beat;

    assign at_last = (idx_q == LAST_IDX);
    assign accept  = valid_c && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        halt_c    = 1'b0;
        clr_c     = 1'b0;
        valid_c   = 1'b0;
        capture_c = 1'b0;
        case (state)
            IDLE: begin
                if (bus.snap_req) begin
                    state_nxt = WAIT_V;
                end
            end
            WAIT_V: begin
                halt_c = 1'b1;
                if (bus.heap_data_v) begin
                    capture_c = 1'b1;
                    state_nxt = CLR;
                end
            end
            CLR: begin
                halt_c    = 1'b1;
                clr_c     = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                valid_c = 1'b1;
                if (bus.out_ready && at_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The snapshot is private to the drain, so the heap may resume during STREAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
        end else if (capture_c) begin
            snap_q <= bus.heap_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else if (state == CLR) begin
            idx_q <= '0;
        end else if (accept) begin
            idx_q <= at_last ? '0 : idx_q + 1'b1;
        end
    end

    // Any request outside IDLE is lost; the flag stays until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= 1'b0;
        end else if (bus.snap_req && (state != IDLE)) begin
            drop_q <= 1'b1;
        end
    end

    regheap_beat_mux u_beat_mux (
        .snap (snap_q),
        .idx  (idx_q),
        .beat (beat)
    );

    assign bus.heap_halt = halt_c;
    assign bus.heap_clr  = clr_c;
    assign bus.out_valid = valid_c;
    assign bus.out_data  = valid_c ? beat : '0;
    assign bus.out_idx   = valid_c ? idx_q : '0;
    assign bus.out_last  = valid_c && at_last;
    assign bus.busy      = (state != IDLE);
    assign bus.snap_drop = drop_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_regheap_drain_64x16b.sv
// Directed bench for regheap_drain_64x16b: latency, beat contents, backpressure,
// dropped requests, asynchronous reset and the optional lane ReLU.
module tb_regheap_drain_64x16b;
    import regheap_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    drain_state_t state_dbg;
    int           checks = 0;
    int           failures = 0;

    regheap_drain_64x16b_if bus_if ();

    regheap_drain_64x16b dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lane i of the ramp pattern holds i*3.
    function automatic logic [63:0] ramp_beat(input int b);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[16*k +: 16] = 16'((4*b + k) * 3);
        end
        return r;
    endfunction

    task automatic load_ramp();
        for (int i = 0; i < LANES; i++) begin
            bus_if.heap_data[16*i +: 16] = 16'(i * 3);
        end
    endtask

    task automatic pulse_snap();
        bus_if.snap_req = 1'b1;
        step();
        bus_if.snap_req = 1'b0;
    endtask

    // Checks beats b0..15 of the ramp with out_ready high, then the return to IDLE.
    task automatic drain_rest(input int b0);
        for (int b = b0; b < NBEATS; b++) begin
            chk($sformatf("data_b%0d", b), bus_if.out_data, ramp_beat(b));
            chk($sformatf("idx_b%0d", b), 64'(bus_if.out_idx), 64'(b));
            chk($sformatf("last_b%0d", b), 64'(bus_if.out_last), 64'(b == NBEATS - 1));
            step();
        end
        chk("end_valid", 64'(bus_if.out_valid), 64'd0);
        chk("end_busy", 64'(bus_if.busy), 64'd0);
    endtask

    initial begin
        bus_if.snap_req    = 1'b0;
        bus_if.heap_data_v = 1'b0;
        bus_if.heap_data   = '0;
        bus_if.out_ready   = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst_halt", 64'(bus_if.heap_halt), 64'd0);
        chk("rst_clr", 64'(bus_if.heap_clr), 64'd0);
        chk("rst_busy", 64'(bus_if.busy), 64'd0);
        chk("rst_drop", 64'(bus_if.snap_drop), 64'd0);
        chk("rst_data", bus_if.out_data, 64'd0);
        chk("rst_state", 64'(state_dbg), 64'(IDLE));
        rst = 1'b0;
        step();

        // Single drain, heap_data_v already high
        load_ramp();
        bus_if.heap_data_v = 1'b1;
        bus_if.out_ready   = 1'b1;
        pulse_snap();
        chk("t1_c1_halt", 64'(bus_if.heap_halt), 64'd1);
        chk("t1_c1_clr", 64'(bus_if.heap_clr), 64'd0);
        chk("t1_c1_valid", 64'(bus_if.out_valid), 64'd0);
        chk("t1_c1_busy", 64'(bus_if.busy), 64'd1);
        step();
        chk("t1_c2_clr", 64'(bus_if.heap_clr), 64'd1);
        chk("t1_c2_halt", 64'(bus_if.heap_halt), 64'd1);
        chk("t1_c2_valid", 64'(bus_if.out_valid), 64'd0);
        step();
        chk("t1_c3_valid", 64'(bus_if.out_valid), 64'd1);
        chk("t1_c3_clr", 64'(bus_if.heap_clr), 64'd0);
        chk("t1_c3_halt", 64'(bus_if.heap_halt), 64'd0);
        chk("t1_beat0", bus_if.out_data, 64'h0009_0006_0003_0000);
        bus_if.heap_data = '1;
        for (int b = 0; b < 15; b++) step();
        chk("t1_beat15", bus_if.out_data, 64'h00BD_00BA_00B7_00B4);
        chk("t1_last15", 64'(bus_if.out_last), 64'd1);
        step();
        chk("t1_end_valid", 64'(bus_if.out_valid), 64'd0);
        chk("t1_end_busy", 64'(bus_if.busy), 64'd0);

        // Late heap_data_v: garbage on the bus until valid rises
        bus_if.heap_data_v = 1'b0;
        bus_if.heap_data   = '1;
        pulse_snap();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_wait_halt%0d", i), 64'(bus_if.heap_halt), 64'd1);
            chk($sformatf("t2_wait_valid%0d", i), 64'(bus_if.out_valid), 64'd0);
            step();
        end
        load_ramp();
        bus_if.heap_data_v = 1'b1;
        chk("t2_c6_halt", 64'(bus_if.heap_halt), 64'd1);
        chk("t2_c6_clr", 64'(bus_if.heap_clr), 64'd0);
        step();
        chk("t2_c7_clr", 64'(bus_if.heap_clr), 64'd1);
        chk("t2_c7_valid", 64'(bus_if.out_valid), 64'd0);
        bus_if.heap_data = '1;
        step();
        chk("t2_c8_valid", 64'(bus_if.out_valid), 64'd1);
        drain_rest(0);

        // Backpressure at beat 5
        load_ramp();
        pulse_snap();
        step();
        step();
        for (int b = 0; b < 5; b++) step();
        bus_if.out_ready = 1'b0;
        for (int s = 0; s < 7; s++) begin
            chk($sformatf("t3_hold_idx%0d", s), 64'(bus_if.out_idx), 64'd5);
            chk($sformatf("t3_hold_data%0d", s), bus_if.out_data, 64'h0045_0042_003F_003C);
            chk($sformatf("t3_hold_valid%0d", s), 64'(bus_if.out_valid), 64'd1);
            step();
        end
        bus_if.out_ready = 1'b1;
        drain_rest(5);

        // Request during STREAM at beat 3 is dropped
        chk("t4_drop_before", 64'(bus_if.snap_drop), 64'd0);
        pulse_snap();
        step();
        step();
        for (int b = 0; b < 3; b++) step();
        chk("t4_idx3", 64'(bus_if.out_idx), 64'd3);
        chk("t4_beat3", bus_if.out_data, 64'h002D_002A_0027_0024);
        pulse_snap();
        chk("t4_drop_set", 64'(bus_if.snap_drop), 64'd1);
        drain_rest(4);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_idle_busy%0d", i), 64'(bus_if.busy), 64'd0);
            step();
        end

        // Asynchronous reset while waiting for heap valid
        bus_if.heap_data_v = 1'b0;
        pulse_snap();
        chk("t5_wait_halt", 64'(bus_if.heap_halt), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_wait_rst_halt", 64'(bus_if.heap_halt), 64'd0);
        chk("t5_wait_rst_busy", 64'(bus_if.busy), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Asynchronous reset mid-stream at beat 9
        bus_if.heap_data_v = 1'b1;
        pulse_snap();
        step();
        step();
        for (int b = 0; b < 9; b++) step();
        chk("t5_idx9", 64'(bus_if.out_idx), 64'd9);
        chk("t5_beat9", bus_if.out_data, 64'h0075_0072_006F_006C);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(bus_if.out_valid), 64'd0);
        chk("t5_rst_halt", 64'(bus_if.heap_halt), 64'd0);
        chk("t5_rst_clr", 64'(bus_if.heap_clr), 64'd0);
        chk("t5_rst_busy", 64'(bus_if.busy), 64'd0);
        chk("t5_rst_last", 64'(bus_if.out_last), 64'd0);
        chk("t5_rst_drop", 64'(bus_if.snap_drop), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Fresh drain after reset; request on the final handshake is dropped
        pulse_snap();
        step();
        step();
        chk("t5_fresh_idx", 64'(bus_if.out_idx), 64'd0);
        chk("t5_fresh_beat0", bus_if.out_data, 64'h0009_0006_0003_0000);
        for (int b = 0; b < 15; b++) step();
        chk("t5_fresh_last", 64'(bus_if.out_last), 64'd1);
        pulse_snap();
        chk("t5_final_drop", 64'(bus_if.snap_drop), 64'd1);
        chk("t5_final_busy", 64'(bus_if.busy), 64'd0);
        step();
        chk("t5_no_redrain", 64'(bus_if.busy), 64'd0);

        // Lane clamp: lane 0 negative, lane 1 max positive
        bus_if.heap_data = '0;
        bus_if.heap_data[15:0]  = 16'hFFFF;
        bus_if.heap_data[31:16] = 16'h7FFF;
        pulse_snap();
        step();
        step();
        chk("t6_valid", 64'(bus_if.out_valid), 64'd1);
`ifdef REGHEAP_DRAIN_RELU_EN
        chk("t6_relu_low32", 64'(bus_if.out_data[31:0]), 64'h7FFF_0000);
`else
        chk("t6_pass_low32", 64'(bus_if.out_data[31:0]), 64'h7FFF_FFFF);
`endif
        for (int b = 0; b < 16; b++) step();
        chk("t6_end_busy", 64'(bus_if.busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
